// File: rtl/ad3552r_spi_responder_if.sv
// SPI pin bundle between the AD3552R controller (master) and the DAC-side responder (slave).
//   spi_cs    : chip select, active low
//   spi_sclk  : SPI clock, mode 0
//   spi_sdi   : 4 lanes driven by the controller
//   spi_sdo   : 4 lanes driven by the responder
//   spi_sdo_t : responder tristate enable, 1 = high-Z
interface ad3552r_spi_responder_if;
    logic       spi_cs;
    logic       spi_sclk;
    logic [3:0] spi_sdi;
    logic [3:0] spi_sdo;
    logic       spi_sdo_t;

    modport master (
        output spi_cs,
        output spi_sclk,
        output spi_sdi,
        input  spi_sdo,
        input  spi_sdo_t
    );

    modport slave (
        input  spi_cs,
        input  spi_sclk,
        input  spi_sdi,
        output spi_sdo,
        output spi_sdo_t
    );
endinterface

// File: rtl/ad3552r_spi_responder.sv
// DAC-side model of the AD3552R SDR SPI interface (single/dual/quad lanes).
// Decodes the instruction byte, writes streamed bytes into a local register
// file (reported on wr_valid/wr_addr/wr_data) or streams register contents
// back on the SDIO lanes. All SPI pins are oversampled on clk.
//   clk, resetn      : oversampling clock (>= 4x sclk), async active-low reset
//   spi              : SPI pin bundle (slave modport)
//   lane_mode        : 0 single, 1 dual, 2 quad, 3 single; latched at cs fall
//   cfg_wr_en/addr/data : local register preload port
//   wr_valid/addr/data  : one-cycle report per completed SPI write byte
//   busy             : transaction in progress
module ad3552r_spi_responder #(
    parameter int unsigned ADDR_WIDTH  = 7,
    parameter bit          ADDR_ASCEND = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    ad3552r_spi_responder_if.slave spi,
    input  logic [1:0]            lane_mode,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [7:0]            cfg_data,
    output logic                  wr_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INSTR = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    // Pin synchronizers; the third stage on cs/sclk is only for edge detection.
    // cs stages reset low so a transaction already running at reset release
    // never produces a falling edge and is ignored.
    logic       cs_s1, cs_s2, cs_s3;
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic [3:0] sdi_s1, sdi_s2;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [7:0]            in_q, in_d;
    logic [7:0]            out_q, out_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [1:0]            mode_q, mode_d;
    logic [3:0]            sdo_q, sdo_d;
    logic                  sdo_t_q, sdo_t_d;

    logic [7:0] regfile [DEPTH];

    logic                  sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
    logic [2:0]            last_cnt_c;
    logic [7:0]            shift_in_c;
    logic [7:0]            shift_out_c;
    logic [3:0]            group_out_c;
    logic                  byte_done_c;
    logic [ADDR_WIDTH-1:0] ptr_step_c;
    logic [ADDR_WIDTH-1:0] instr_addr_c;
    logic                  spi_we_c;

    // Synchronizer and edge-detect pipeline
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cs_s1   <= 1'b0;
            cs_s2   <= 1'b0;
            cs_s3   <= 1'b0;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            sdi_s1  <= 4'h0;
            sdi_s2  <= 4'h0;
        end else begin
            cs_s1   <= spi.spi_cs;
            cs_s2   <= cs_s1;
            cs_s3   <= cs_s2;
            sclk_s1 <= spi.spi_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            sdi_s1  <= spi.spi_sdi;
            sdi_s2  <= sdi_s1;
        end
    end

    assign sclk_rise_c = sclk_s2 & ~sclk_s3;
    assign sclk_fall_c = ~sclk_s2 & sclk_s3;
    assign cs_fall_c   = ~cs_s2 & cs_s3;
    assign cs_rise_c   = cs_s2 & ~cs_s3;

    // Lane-mode dependent shifting: MSB first, highest lane carries highest bit
    always_comb begin
        last_cnt_c  = 3'd7;
        shift_in_c  = {in_q[6:0], sdi_s2[0]};
        shift_out_c = {out_q[6:0], 1'b0};
        group_out_c = {2'b00, out_q[7], 1'b0};
        case (mode_q)
            2'd1: begin
                last_cnt_c  = 3'd3;
                shift_in_c  = {in_q[5:0], sdi_s2[1:0]};
                shift_out_c = {out_q[5:0], 2'b00};
                group_out_c = {2'b00, out_q[7:6]};
            end
            2'd2: begin
                last_cnt_c  = 3'd1;
                shift_in_c  = {in_q[3:0], sdi_s2[3:0]};
                shift_out_c = {out_q[3:0], 4'h0};
                group_out_c = out_q[7:4];
            end
            default: ;
        endcase
    end

    assign byte_done_c  = sclk_rise_c && (cnt_q == last_cnt_c);
    assign ptr_step_c   = ADDR_ASCEND ? (ptr_q + ADDR_WIDTH'(1)) : (ptr_q - ADDR_WIDTH'(1));
    assign instr_addr_c = ADDR_WIDTH'(shift_in_c[6:0]);

    // Next-state and datapath decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        in_d     = in_q;
        out_d    = out_q;
        ptr_d    = ptr_q;
        mode_d   = mode_q;
        sdo_d    = sdo_q;
        sdo_t_d  = sdo_t_q;
        spi_we_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (cs_fall_c) begin
                    state_d = INSTR;
                    cnt_d   = 3'd0;
                    in_d    = 8'h00;
                    mode_d  = lane_mode;
                    sdo_d   = 4'h0;
                    sdo_t_d = 1'b1;
                end
            end
            INSTR: begin
                if (sclk_rise_c) begin
                    in_d  = shift_in_c;
                    cnt_d = cnt_q + 3'd1;
                    if (byte_done_c) begin
                        cnt_d = 3'd0;
                        ptr_d = instr_addr_c;
                        if (shift_in_c[7]) begin
                            state_d = READ;
                            out_d   = regfile[instr_addr_c];
                        end else begin
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                if (sclk_rise_c) begin
                    in_d  = shift_in_c;
                    cnt_d = cnt_q + 3'd1;
                    if (byte_done_c) begin
                        cnt_d    = 3'd0;
                        spi_we_c = 1'b1;
                        ptr_d    = ptr_step_c;
                    end
                end
            end
            READ: begin
                // cnt counts bit groups already presented in the current byte
                if (sclk_fall_c) begin
                    sdo_d   = group_out_c;
                    sdo_t_d = 1'b0;
                    if (cnt_q == last_cnt_c) begin
                        cnt_d = 3'd0;
                        ptr_d = ptr_step_c;
                        out_d = regfile[ptr_step_c];
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        out_d = shift_out_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // cs release ends any transaction; a byte completing on this cycle still writes
        if (cs_rise_c) begin
            state_d = IDLE;
            sdo_d   = 4'h0;
            sdo_t_d = 1'b1;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            in_q     <= 8'h00;
            out_q    <= 8'h00;
            ptr_q    <= '0;
            mode_q   <= 2'd0;
            sdo_q    <= 4'h0;
            sdo_t_q  <= 1'b1;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'h00;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in_q     <= in_d;
            out_q    <= out_d;
            ptr_q    <= ptr_d;
            mode_q   <= mode_d;
            sdo_q    <= sdo_d;
            sdo_t_q  <= sdo_t_d;
            wr_valid <= spi_we_c;
            busy     <= (state_d != IDLE);
            if (spi_we_c) begin
                wr_addr <= ptr_q;
                wr_data <= shift_in_c;
            end
        end
    end

    // Register file; SPI write is ordered last so it wins an address collision
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            regfile <= '{default: 8'h00};
        end else begin
            if (cfg_wr_en) begin
                regfile[cfg_addr] <= cfg_data;
            end
            if (spi_we_c) begin
                regfile[ptr_q] <= shift_in_c;
            end
        end
    end

    assign spi.spi_sdo   = sdo_q;
    assign spi.spi_sdo_t = sdo_t_q;

endmodule

// File: tb/tb_ad3552r_spi_responder.sv
// Self-checking bench for ad3552r_spi_responder. Two instances share the SPI
// master pins: one with ascending and one with descending address stepping.
// A byte-level reference model (one array per instance) predicts writes and
// read-back data for directed and randomized transactions.
module tb_ad3552r_spi_responder;

    localparam int unsigned AW = 7;
    localparam int unsigned HP = 60;   // sclk half period in time units (6 clk)

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wev_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cs;
    logic          sclk;
    logic [3:0]    sdi;
    logic [1:0]    lane_mode;
    logic          cfg_wr_en;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_data;

    logic          wr_valid_a, wr_valid_d;
    logic [AW-1:0] wr_addr_a, wr_addr_d;
    logic [7:0]    wr_data_a, wr_data_d;
    logic          busy_a, busy_d;

    ad3552r_spi_responder_if if_a ();
    ad3552r_spi_responder_if if_d ();

    assign if_a.spi_cs   = cs;
    assign if_a.spi_sclk = sclk;
    assign if_a.spi_sdi  = sdi;
    assign if_d.spi_cs   = cs;
    assign if_d.spi_sclk = sclk;
    assign if_d.spi_sdi  = sdi;

    ad3552r_spi_responder #(.ADDR_WIDTH(AW), .ADDR_ASCEND(1'b1)) u_dut_a (
        .clk       (clk),
        .resetn    (resetn),
        .spi       (if_a.slave),
        .lane_mode (lane_mode),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .wr_valid  (wr_valid_a),
        .wr_addr   (wr_addr_a),
        .wr_data   (wr_data_a),
        .busy      (busy_a)
    );

    ad3552r_spi_responder #(.ADDR_WIDTH(AW), .ADDR_ASCEND(1'b0)) u_dut_d (
        .clk       (clk),
        .resetn    (resetn),
        .spi       (if_d.slave),
        .lane_mode (lane_mode),
        .cfg_wr_en (cfg_wr_en),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .wr_valid  (wr_valid_d),
        .wr_addr   (wr_addr_d),
        .wr_data   (wr_data_d),
        .busy      (busy_d)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl_a [128];
    logic [7:0] mdl_d [128];
    wev_t       q_a [$];
    wev_t       q_d [$];

    logic [7:0] tx    [16];
    logic [3:0] rx_a  [64];
    logic [3:0] rx_d  [64];
    logic       rxt_a [64];
    int         rst_grp      = -1;
    bit         cs_with_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every write report of both instances
    always @(negedge clk) begin
        if (wr_valid_a) q_a.push_back({wr_addr_a, wr_data_a});
        if (wr_valid_d) q_d.push_back({wr_addr_d, wr_data_d});
    end

    function automatic int bits_of(input logic [1:0] mode);
        return (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 128; i++) begin
            mdl_a[i] = 8'h00;
            mdl_d[i] = 8'h00;
        end
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
        mdl_a[a]  = d;
        mdl_d[a]  = d;
    endtask

    // Drive n_groups sclk cycles from tx[]; sample sdo just before each rising edge
    task automatic xfer(input logic [1:0] mode, input int n_groups);
        int         bits;
        int         gpb;
        int         pos;
        logic [7:0] sh;
        bits      = bits_of(mode);
        gpb       = 8 / bits;
        lane_mode = mode;
        @(negedge clk);
        cs   = 1'b0;
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n_groups; i++) begin
            pos = i % gpb;
            sh  = tx[i / gpb] << (pos * bits);
            case (bits)
                1:       sdi = {3'b000, sh[7]};
                2:       sdi = {2'b00, sh[7:6]};
                default: sdi = sh[7:4];
            endcase
            #(HP);
            rx_a[i]  = if_a.spi_sdo;
            rx_d[i]  = if_d.spi_sdo;
            rxt_a[i] = if_a.spi_sdo_t;
            if (i == 0) check("busy_active", 32'(busy_a), 32'd1);
            if (i == rst_grp) begin
                resetn = 1'b0;
                #1;
                check("rst_sdo_t", 32'(if_a.spi_sdo_t), 32'd1);
                check("rst_sdo", 32'(if_a.spi_sdo), 32'd0);
                check("rst_busy", 32'(busy_a), 32'd0);
                check("rst_wr_valid", 32'(wr_valid_a), 32'd0);
                model_clear();
                #19;
                resetn = 1'b1;
            end
            sclk = 1'b1;
            if (cs_with_last && (i == n_groups - 1)) cs = 1'b1;
            #(HP);
            sclk = 1'b0;
        end
        #(HP);
        cs  = 1'b1;
        sdi = 4'h0;
        repeat (8) @(negedge clk);
    endtask

    // One transaction checked against the byte-level model
    task automatic run_txn(input logic [1:0] mode, input int n_groups, input string tag);
        int            bits;
        int            gpb;
        int            nb;
        logic          rd;
        logic [AW-1:0] a;
        logic [AW-1:0] aa;
        logic [AW-1:0] ad;
        logic [7:0]    ba;
        logic [7:0]    bd;
        logic [3:0]    g;
        logic          t_ok;
        bits = bits_of(mode);
        gpb  = 8 / bits;
        q_a.delete();
        q_d.delete();
        xfer(mode, n_groups);
        nb = (n_groups >= gpb) ? (n_groups / gpb - 1) : 0;
        rd = tx[0][7];
        a  = tx[0][AW-1:0];
        t_ok = 1'b1;
        for (int i = 0; i < gpb && i < n_groups; i++) t_ok &= rxt_a[i];
        check({tag, "_sdo_t_instr"}, 32'(t_ok), 32'd1);
        if (!rd || n_groups < gpb) begin
            check({tag, "_wcnt_a"}, 32'(q_a.size()), 32'(nb));
            check({tag, "_wcnt_d"}, 32'(q_d.size()), 32'(nb));
            for (int k = 0; k < nb; k++) begin
                aa = a + AW'(k);
                ad = a - AW'(k);
                if (k < q_a.size()) check({tag, "_wev_a"}, 32'(q_a[k]), 32'({aa, tx[k + 1]}));
                if (k < q_d.size()) check({tag, "_wev_d"}, 32'(q_d[k]), 32'({ad, tx[k + 1]}));
                mdl_a[aa] = tx[k + 1];
                mdl_d[ad] = tx[k + 1];
            end
        end else begin
            check({tag, "_rd_nowrite"}, 32'(q_a.size() + q_d.size()), 32'd0);
            for (int k = 0; k < nb; k++) begin
                aa   = a + AW'(k);
                ad   = a - AW'(k);
                ba   = 8'h00;
                bd   = 8'h00;
                t_ok = 1'b1;
                for (int j = 0; j < gpb; j++) begin
                    t_ok &= ~rxt_a[(k + 1) * gpb + j];
                    g = rx_a[(k + 1) * gpb + j];
                    case (bits)
                        1:       ba = {ba[6:0], g[1]};
                        2:       ba = {ba[5:0], g[1:0]};
                        default: ba = {ba[3:0], g};
                    endcase
                    g = rx_d[(k + 1) * gpb + j];
                    case (bits)
                        1:       bd = {bd[6:0], g[1]};
                        2:       bd = {bd[5:0], g[1:0]};
                        default: bd = {bd[3:0], g};
                    endcase
                end
                check({tag, "_rdata_a"}, 32'(ba), 32'(mdl_a[aa]));
                check({tag, "_rdata_d"}, 32'(bd), 32'(mdl_d[ad]));
                check({tag, "_sdo_t_data"}, 32'(t_ok), 32'd1);
            end
        end
        check({tag, "_busy_end"}, 32'(busy_a), 32'd0);
        check({tag, "_sdo_t_end"}, 32'(if_a.spi_sdo_t), 32'd1);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            mode_r;
        int            nbytes;
        int            ng;
        int            gpb;
        logic [AW-1:0] ra;

        resetn    = 1'b0;
        cs        = 1'b1;
        sclk      = 1'b0;
        sdi       = 4'h0;
        lane_mode = 2'd0;
        cfg_wr_en = 1'b0;
        cfg_addr  = '0;
        cfg_data  = 8'h00;
        model_clear();
        repeat (4) @(negedge clk);
        check("reset_sdo", 32'(if_a.spi_sdo), 32'd0);
        check("reset_sdo_t", 32'(if_a.spi_sdo_t), 32'd1);
        check("reset_wr_valid", 32'(wr_valid_a), 32'd0);
        check("reset_wr_addr", 32'(wr_addr_a), 32'd0);
        check("reset_wr_data", 32'(wr_data_a), 32'd0);
        check("reset_busy", 32'(busy_a), 32'd0);
        resetn = 1'b1;
        repeat (6) @(negedge clk);

        // Single-lane write 0x05 <- 0x2C, then read it back
        tx[0] = 8'h05; tx[1] = 8'h2C;
        run_txn(2'd0, 16, "single_wr");
        tx[0] = 8'h85;
        run_txn(2'd0, 16, "single_rd");

        // Quad stream write from 0x2A
        tx[0] = 8'h2A; tx[1] = 8'hAA; tx[2] = 8'h55;
        run_txn(2'd2, 6, "quad_wr");

        // Dual read of a preloaded byte: groups 00,11,11,00
        cfg_write(AW'(8'h10), 8'h3C);
        tx[0] = 8'h90;
        run_txn(2'd1, 8, "dual_rd");
        check("dual_grp0", 32'(rx_a[4][1:0]), 32'd0);
        check("dual_grp1", 32'(rx_a[5][1:0]), 32'd3);
        check("dual_grp2", 32'(rx_a[6][1:0]), 32'd3);
        check("dual_grp3", 32'(rx_a[7][1:0]), 32'd0);

        // Abort after 5 data bits, then confirm 0x03 kept its value
        cfg_write(AW'(8'h03), 8'h81);
        tx[0] = 8'h03; tx[1] = 8'hF0;
        run_txn(2'd0, 13, "abort_wr");
        tx[0] = 8'h83;
        run_txn(2'd0, 16, "abort_rd");

        // Address wrap in both directions
        tx[0] = 8'h7F; tx[1] = 8'h11; tx[2] = 8'h22;
        run_txn(2'd0, 24, "wrap_7f");
        check("wrap_asc_second", 32'(q_a.size() > 1 ? q_a[1].a : AW'(8'h55)), 32'h00);
        tx[0] = 8'h00;
        run_txn(2'd0, 24, "wrap_00");
        check("wrap_desc_second", 32'(q_d.size() > 1 ? q_d[1].a : AW'(8'h55)), 32'h7F);

        // cs released together with the final rising edge: byte still lands
        tx[0] = 8'h40; tx[1] = 8'hC3;
        cs_with_last = 1'b1;
        run_txn(2'd0, 16, "cs_last_wr");
        cs_with_last = 1'b0;
        tx[0] = 8'hC0;
        run_txn(2'd0, 16, "cs_last_rd");

        // Reset during a dual read data phase
        tx[0] = 8'h90; tx[1] = 8'h00;
        rst_grp = 10;
        q_a.delete();
        xfer(2'd1, 12);
        rst_grp = -1;
        check("rst_no_write", 32'(q_a.size()), 32'd0);
        check("rst_busy_after", 32'(busy_a), 32'd0);
        tx[0] = 8'h90;
        run_txn(2'd1, 8, "post_rst_rd");
        tx[0] = 8'h21; tx[1] = 8'h5A;
        run_txn(2'd2, 4, "post_rst_wr");
        tx[0] = 8'hA1;
        run_txn(2'd2, 4, "post_rst_rb");

        // Randomized traffic, including reserved mode and truncated bytes
        for (int t = 0; t < 36; t++) begin
            if ($urandom_range(0, 4) == 0) cfg_write(AW'($urandom_range(0, 127)), 8'($urandom()));
            mode_r = $urandom_range(0, 3);
            nbytes = $urandom_range(1, 4);
            ra     = AW'($urandom_range(0, 127));
            tx[0]  = {1'($urandom_range(0, 1)), ra};
            for (int k = 1; k <= nbytes; k++) tx[k] = 8'($urandom());
            gpb = 8 / bits_of(2'(mode_r));
            ng  = (nbytes + 1) * gpb;
            if ($urandom_range(0, 5) == 0) ng = ng - $urandom_range(1, gpb - 1);
            if (ng < 1) ng = 1;
            run_txn(2'(mode_r), ng, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
